// File: rtl/subckt_sweep_ctrl.sv
// Exhaustive sweep controller for a 4-input combinational sub-circuit: drives all 16 input codes and captures the truth table.
// Define SWEEP_GRAY_ORDER_EN to visit codes in Gray order; otherwise they are visited in binary order.
module subckt_sweep_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        resp,
    output logic [3:0]  vec,
    output logic        busy,
    output logic        done,
    output logic        res_valid,
    output logic [15:0] truth,
    output logic [4:0]  ones_cnt,
    output logic [4:0]  tog_cnt
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [3:0] LAST_STEP = 4'd15;

    // Maps the sweep step to the code driven onto the sub-circuit.
    function automatic logic [3:0] order_of(input logic [3:0] idx);
`ifdef SWEEP_GRAY_ORDER_EN
        return idx ^ (idx >> 1);
`else
        return idx;
`endif
    endfunction

    logic [1:0]  r_state;
    logic [3:0]  r_step;
    logic [3:0]  r_vec;
    logic        r_done;
    logic        r_res_valid;
    logic [15:0] r_truth;
    logic [4:0]  r_ones;
    logic [4:0]  r_tog;
    logic        r_prev;

    logic [1:0]  w_state_nxt;
    logic [3:0]  w_step_nxt;
    logic [3:0]  w_vec_nxt;
    logic        w_done_nxt;
    logic        w_res_valid_nxt;
    logic [15:0] w_truth_nxt;
    logic [4:0]  w_ones_nxt;
    logic [4:0]  w_tog_nxt;
    logic        w_prev_nxt;

    always_comb begin
        // NOTE: every signal gets a hold default first so no path leaves it unassigned (which would infer a latch).
        w_state_nxt     = r_state;
        w_step_nxt      = r_step;
        w_vec_nxt       = r_vec;
        w_done_nxt      = 1'b0;
        w_res_valid_nxt = r_res_valid;
        w_truth_nxt     = r_truth;
        w_ones_nxt      = r_ones;
        w_tog_nxt       = r_tog;
        w_prev_nxt      = r_prev;

        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt     = ST_SETTLE;
                    w_step_nxt      = 4'd0;
                    w_vec_nxt       = order_of(4'd0);
                    w_res_valid_nxt = 1'b0;
                    w_truth_nxt     = 16'd0;
                    w_ones_nxt      = 5'd0;
                    w_tog_nxt       = 5'd0;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    w_state_nxt     = ST_IDLE;
                    w_res_valid_nxt = 1'b0;
                end else begin
                    w_state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    // Abandon the sweep but keep the partial counts for inspection.
                    w_state_nxt     = ST_IDLE;
                    w_res_valid_nxt = 1'b0;
                end else begin
                    w_truth_nxt[r_vec] = resp;
                    w_ones_nxt         = r_ones + {4'd0, resp};
                    if ((r_step != 4'd0) && (resp != r_prev)) begin
                        w_tog_nxt = r_tog + 5'd1;
                    end
                    w_prev_nxt = resp;
                    if (r_step != LAST_STEP) begin
                        w_step_nxt  = r_step + 4'd1;
                        w_vec_nxt   = order_of(r_step + 4'd1);
                        w_state_nxt = ST_SETTLE;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt     = ST_IDLE;
                w_done_nxt      = 1'b1;
                w_res_valid_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // NOTE: truth is a bank of flops rather than RAM, so it is cleared by reset along with the rest of the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_step      <= 4'd0;
            r_vec       <= 4'd0;
            r_done      <= 1'b0;
            r_res_valid <= 1'b0;
            r_truth     <= 16'd0;
            r_ones      <= 5'd0;
            r_tog       <= 5'd0;
            r_prev      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state     <= w_state_nxt;
            r_step      <= w_step_nxt;
            r_vec       <= w_vec_nxt;
            r_done      <= w_done_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_truth     <= w_truth_nxt;
            r_ones      <= w_ones_nxt;
            r_tog       <= w_tog_nxt;
            r_prev      <= w_prev_nxt;
        end
    end

    assign vec       = r_vec;
    assign busy      = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
    assign done      = r_done;
    assign res_valid = r_res_valid;
    assign truth     = r_truth;
    assign ones_cnt  = r_ones;
    assign tog_cnt   = r_tog;

endmodule
